// File: rtl/vga_pkg.sv
// Shared constants, coordinate types and writer FSM states
// for the VGA framebuffer write path.
package vga_pkg;

   localparam int HSYNC_BITS = 11;
   localparam int VSYNC_BITS = 11;
   localparam int HD         = 1280;
   localparam int VD         = 1024;
   localparam int COLOR_BITS = 2;

   typedef logic [HSYNC_BITS-1:0] coord_x_t;
   typedef logic [VSYNC_BITS-1:0] coord_y_t;
   typedef logic [COLOR_BITS-1:0] color_t;

   typedef enum logic [1:0] {
      IDLE,
      CLIP,
      FILL,
      DONE
   } wr_state_e;

endpackage

// File: rtl/vga_rect_writer_if.sv
// Command handshake and framebuffer write port of the
// rectangle writer, bundled with master/slave views.
interface vga_rect_writer_if;
   import vga_pkg::*;

   logic     cmd_valid_i;
   logic     cmd_ready_o;
   coord_x_t cmd_x0_i;
   coord_y_t cmd_y0_i;
   coord_x_t cmd_x1_i;
   coord_y_t cmd_y1_i;
   color_t   cmd_color_i;
   logic     wr_ready_i;
   coord_x_t addr_x_o;
   coord_y_t addr_y_o;
   color_t   color_o;
   logic     we_o;
   logic     busy_o;
   logic     done_o;

   modport master (
      output cmd_valid_i,
      output cmd_x0_i,
      output cmd_y0_i,
      output cmd_x1_i,
      output cmd_y1_i,
      output cmd_color_i,
      output wr_ready_i,
      input  cmd_ready_o,
      input  addr_x_o,
      input  addr_y_o,
      input  color_o,
      input  we_o,
      input  busy_o,
      input  done_o
   );

   modport slave (
      input  cmd_valid_i,
      input  cmd_x0_i,
      input  cmd_y0_i,
      input  cmd_x1_i,
      input  cmd_y1_i,
      input  cmd_color_i,
      input  wr_ready_i,
      output cmd_ready_o,
      output addr_x_o,
      output addr_y_o,
      output color_o,
      output we_o,
      output busy_o,
      output done_o
   );

endinterface

// File: rtl/vga_rect_clip.sv
// Orders two rectangle corners, clamps the far edge to the
// visible area and flags rectangles that start off-screen.
module vga_rect_clip
   import vga_pkg::*;
(
   input  coord_x_t x0,
   input  coord_y_t y0,
   input  coord_x_t x1,
   input  coord_y_t y1,
   output coord_x_t xl,
   output coord_x_t xh,
   output coord_y_t yl,
   output coord_y_t yh,
   output logic     reject
);

   localparam coord_x_t XMAX = coord_x_t'(HD - 1);
   localparam coord_y_t YMAX = coord_y_t'(VD - 1);

   coord_x_t xh_raw;
   coord_y_t yh_raw;

   assign xl     = (x0 < x1) ? x0 : x1;
   assign xh_raw = (x0 < x1) ? x1 : x0;
   assign yl     = (y0 < y1) ? y0 : y1;
   assign yh_raw = (y0 < y1) ? y1 : y0;

   assign xh = (xh_raw > XMAX) ? XMAX : xh_raw;
   assign yh = (yh_raw > YMAX) ? YMAX : yh_raw;

   // Low corner past the last visible pixel means nothing to draw.
   assign reject = (xl > XMAX) || (yl > YMAX);

endmodule

// File: rtl/vga_rect_writer.sv
// Rectangle fill initiator: takes one command, clips it, then
// streams pixel writes in raster order to the framebuffer.
module vga_rect_writer
   import vga_pkg::*;
(
   input logic              clk_i,
   input logic              arstn_i,
   vga_rect_writer_if.slave bus
);

   wr_state_e state;

   coord_x_t x0_q;
   coord_y_t y0_q;
   coord_x_t x1_q;
   coord_y_t y1_q;
   color_t   col_q;

   coord_x_t xl_q;
   coord_x_t xh_q;
   coord_y_t yh_q;

   coord_x_t x_q;
   coord_y_t y_q;
   color_t   color_q;
   logic     we_q;
   logic     ready_q;
   logic     busy_q;
   logic     done_q;

   coord_x_t c_xl;
   coord_x_t c_xh;
   coord_y_t c_yl;
   coord_y_t c_yh;
   logic     c_reject;

   vga_rect_clip u_clip (
      .x0     (x0_q),
      .y0     (y0_q),
      .x1     (x1_q),
      .y1     (y1_q),
      .xl     (c_xl),
      .xh     (c_xh),
      .yl     (c_yl),
      .yh     (c_yh),
      .reject (c_reject)
   );

   // Command FSM, fill counters and registered port outputs.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state   <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         col_q   <= '0;
         xl_q    <= '0;
         xh_q    <= '0;
         yh_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               if (bus.cmd_valid_i && ready_q) begin
                  x0_q    <= bus.cmd_x0_i;
                  y0_q    <= bus.cmd_y0_i;
                  x1_q    <= bus.cmd_x1_i;
                  y1_q    <= bus.cmd_y1_i;
                  col_q   <= bus.cmd_color_i;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= CLIP;
               end
            end
            CLIP: begin
               if (c_reject) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  xl_q    <= c_xl;
                  xh_q    <= c_xh;
                  yh_q    <= c_yh;
                  x_q     <= c_xl;
                  y_q     <= c_yl;
                  color_q <= col_q;
                  we_q    <= 1'b1;
                  state   <= FILL;
               end
            end
            FILL: begin
               if (bus.wr_ready_i) begin
                  if (x_q < xh_q) begin
                     x_q <= x_q + 1'b1;
                  end else if (y_q < yh_q) begin
                     x_q <= xl_q;
                     y_q <= y_q + 1'b1;
                  end else begin
                     we_q   <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready_o = ready_q;
   assign bus.addr_x_o    = x_q;
   assign bus.addr_y_o    = y_q;
   assign bus.color_o     = color_q;
   assign bus.we_o        = we_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;

endmodule

// File: tb/tb_vga_rect_writer.sv
// Directed bench for vga_rect_writer: order, clipping, reject,
// backpressure and reset during a fill.
module tb_vga_rect_writer;

   logic clk_i = 1'b0;
   logic arstn_i;

   vga_rect_writer_if bus ();

   vga_rect_writer dut (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_pass = 0;

   logic [23:0] wq[$];

   int first_we;
   int done_at;
   int we_first_cyc;
   int rdy_busy;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Present a command and return at the negedge after acceptance.
   task automatic send(input int x0, input int y0, input int x1,
                       input int y1, input int c);
      int n;
      bus.cmd_x0_i    = 11'(x0);
      bus.cmd_y0_i    = 11'(y0);
      bus.cmd_x1_i    = 11'(x1);
      bus.cmd_y1_i    = 11'(y1);
      bus.cmd_color_i = 2'(c);
      bus.cmd_valid_i = 1'b1;
      n = 0;
      while (!bus.cmd_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 0, 1);
      @(negedge clk_i);
      bus.cmd_valid_i = 1'b0;
   endtask

   // Watch cycles after acceptance until done_o, logging writes.
   task automatic collect(input int stall, input int max);
      int fx;
      int fy;
      first_we     = -1;
      done_at      = -1;
      we_first_cyc = 0;
      rdy_busy     = 0;
      fx = -1;
      fy = -1;
      wq.delete();
      for (int k = 1; k <= max; k++) begin
         bus.wr_ready_i = (k >= 2 && k < 2 + stall) ? 1'b0 : 1'b1;
         if (bus.we_o && first_we < 0) begin
            first_we = k;
            fx = int'(bus.addr_x_o);
            fy = int'(bus.addr_y_o);
         end
         if (bus.we_o && int'(bus.addr_x_o) == fx &&
             int'(bus.addr_y_o) == fy)
            we_first_cyc++;
         if (bus.cmd_ready_o) rdy_busy++;
         if (bus.we_o && bus.wr_ready_i)
            wq.push_back({bus.addr_x_o, bus.addr_y_o, bus.color_o});
         if (bus.done_o) begin
            done_at = k;
            break;
         end
         @(negedge clk_i);
      end
      bus.wr_ready_i = 1'b1;
      if (done_at < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic check_writes(input string tag, input int xl,
                               input int xh, input int yl,
                               input int yh, input int c);
      int i;
      logic [23:0] e;
      i = 0;
      chk({tag, "_count"}, wq.size(), (xh - xl + 1) * (yh - yl + 1));
      for (int y = yl; y <= yh; y++) begin
         for (int x = xl; x <= xh; x++) begin
            e = {11'(x), 11'(y), 2'(c)};
            if (i < wq.size()) chk({tag, "_pix"}, wq[i], e);
            i++;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk_i);
      chk({tag, "_busy"}, bus.busy_o, 0);
      chk({tag, "_ready"}, bus.cmd_ready_o, 1);
      chk({tag, "_we"}, bus.we_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      arstn_i         = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_x0_i    = '0;
      bus.cmd_y0_i    = '0;
      bus.cmd_x1_i    = '0;
      bus.cmd_y1_i    = '0;
      bus.cmd_color_i = '0;
      bus.wr_ready_i  = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_ready", bus.cmd_ready_o, 0);
      chk("rst_we", bus.we_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_addr", {bus.addr_x_o, bus.addr_y_o, bus.color_o}, 0);
      arstn_i = 1'b1;

      send(2, 3, 4, 4, 2);
      collect(0, 100);
      chk("t1_first_we", first_we, 2);
      chk("t1_done_at", done_at, 8);
      check_writes("t1", 2, 4, 3, 4, 2);
      check_idle("t1");

      send(4, 4, 2, 3, 2);
      collect(0, 100);
      chk("t2_first_we", first_we, 2);
      chk("t2_done_at", done_at, 8);
      check_writes("t2", 2, 4, 3, 4, 2);
      check_idle("t2");

      send(1278, 1022, 2000, 2000, 3);
      collect(0, 100);
      chk("t3_done_at", done_at, 6);
      check_writes("t3", 1278, 1279, 1022, 1023, 3);
      check_idle("t3");

      send(1280, 5, 1500, 9, 1);
      collect(0, 100);
      chk("t4_we_seen", first_we, -1);
      chk("t4_done_at", done_at, 2);
      chk("t4_nwr", wq.size(), 0);
      check_idle("t4");

      send(0, 0, 1, 0, 1);
      bus.cmd_x0_i    = 11'd7;
      bus.cmd_y0_i    = 11'd7;
      bus.cmd_x1_i    = 11'd7;
      bus.cmd_y1_i    = 11'd7;
      bus.cmd_color_i = 2'd3;
      bus.cmd_valid_i = 1'b1;
      collect(3, 100);
      chk("t5_hold", we_first_cyc, 4);
      chk("t5_done_at", done_at, 7);
      chk("t5_rdy_busy", rdy_busy, 0);
      check_writes("t5", 0, 1, 0, 0, 1);
      send(7, 7, 7, 7, 3);
      collect(0, 100);
      chk("t5b_done_at", done_at, 3);
      check_writes("t5b", 7, 7, 7, 7, 3);
      check_idle("t5b");

      send(0, 0, 9, 0, 2);
      repeat (3) @(negedge clk_i);
      chk("t6_pre_we", bus.we_o, 1);
      chk("t6_pre_x", bus.addr_x_o, 2);
      arstn_i = 1'b0;
      #1;
      chk("t6_we", bus.we_o, 0);
      chk("t6_addr", {bus.addr_x_o, bus.addr_y_o, bus.color_o}, 0);
      chk("t6_ready", bus.cmd_ready_o, 0);
      chk("t6_busy", bus.busy_o, 0);
      repeat (2) @(negedge clk_i);
      arstn_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t6_ready_after", bus.cmd_ready_o, 1);
      send(5, 5, 5, 5, 1);
      collect(0, 100);
      chk("t6_first_we", first_we, 2);
      chk("t6_done_at", done_at, 3);
      check_writes("t6", 5, 5, 5, 5, 1);
      check_idle("t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
